// File: rtl/dump_serializer_if.sv
// dump_serializer_if: trigger, core-state debug read and UART TX byte signals of the dump serializer.
interface dump_serializer_if;
  logic        trigger_i;
  logic        mem_mode_i;
  logic        done_o;
  logic        busy_o;
  logic [31:0] pc_i;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_i;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_data_i;
  logic        mem_we_i;
  logic [31:0] mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  modport master (
    input  trigger_i, mem_mode_i, pc_i, rf_data_i, dmem_data_i,
    input  mem_we_i, mem_waddr_i, mem_wdata_i, tx_ready_i,
    output done_o, busy_o, rf_addr_o, dmem_addr_o, tx_data_o, tx_valid_o
  );
  modport slave (
    output trigger_i, mem_mode_i, pc_i, rf_data_i, dmem_data_i,
    output mem_we_i, mem_waddr_i, mem_wdata_i, tx_ready_i,
    input  done_o, busy_o, rf_addr_o, dmem_addr_o, tx_data_o, tx_valid_o
  );
endinterface

// File: rtl/dump_serializer.sv
// dump_serializer: on trigger, streams PC, x0..x31 and a memory section (last write or word range) as a byte frame.
module dump_serializer #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64,
  parameter logic [7:0]  HDR_BYTE  = 8'hDA,
  parameter logic [7:0]  TRL_BYTE  = 8'hED
) (
  input logic              clk_i,
  input logic              rst_i,
  dump_serializer_if.master bus
);
  localparam int MW = $clog2(MEM_WORDS) + 1;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_PC, S_RF_REQ, S_RF_LAT, S_WORD_TX,
    S_MEM_FLAG, S_MEM_REQ, S_MEM_LAT, S_TRL, S_DONE
  } state_e;
  typedef enum logic [1:0] {W_RF, W_MEM, W_DADDR, W_DDATA} src_e;
  state_e          state_q, state_d;
  src_e            src_q, src_d;
  logic            mode_q, mode_d;
  logic [31:0]     shift_q, shift_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [4:0]      rf_idx_q, rf_idx_d;
  logic [MW-1:0]   mem_idx_q, mem_idx_d;
  logic [31:0]     dmem_addr_q, dmem_addr_d;
  logic            wr_flag_q, wr_flag_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic [31:0]     diff_data_q, diff_data_d;
  logic            acc;
  assign acc = bus.tx_valid_o && bus.tx_ready_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      src_q       <= W_RF;
      mode_q      <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      rf_idx_q    <= '0;
      mem_idx_q   <= '0;
      dmem_addr_q <= '0;
      wr_flag_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      diff_data_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rf_idx_q    <= rf_idx_d;
      mem_idx_q   <= mem_idx_d;
      dmem_addr_q <= dmem_addr_d;
      wr_flag_q   <= wr_flag_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      diff_data_q <= diff_data_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rf_idx_d    = rf_idx_q;
    mem_idx_d   = mem_idx_q;
    dmem_addr_d = dmem_addr_q;
    wr_flag_d   = wr_flag_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    diff_data_d = diff_data_q;
    case (state_q)
      S_IDLE: if (bus.trigger_i) begin
        mode_d  = bus.mem_mode_i;
        shift_d = bus.pc_i;
        state_d = S_HDR;
      end
      S_HDR: if (acc) begin
        cnt_d   = '0;
        state_d = S_PC;
      end
      S_PC: if (acc) begin
        shift_d = shift_q >> 8;
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? S_RF_REQ : S_PC;
      end
      S_RF_REQ: state_d = S_RF_LAT;
      S_RF_LAT: begin
        shift_d = bus.rf_data_i;
        src_d   = W_RF;
        state_d = S_WORD_TX;
      end
      S_WORD_TX: if (acc) begin
        shift_d = shift_q >> 8;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          case (src_q)
            W_RF: begin
              rf_idx_d    = rf_idx_q + 5'd1;
              mem_idx_d   = '0;
              dmem_addr_d = (rf_idx_q == 5'd31 && mode_q) ? MEM_BASE : dmem_addr_q;
              state_d     = (rf_idx_q != 5'd31) ? S_RF_REQ : mode_q ? S_MEM_REQ : S_MEM_FLAG;
            end
            W_MEM: begin
              mem_idx_d   = mem_idx_q + MW'(1);
              dmem_addr_d = (mem_idx_q == MW'(MEM_WORDS - 1)) ? dmem_addr_q : dmem_addr_q + 32'd4;
              state_d     = (mem_idx_q == MW'(MEM_WORDS - 1)) ? S_TRL : S_MEM_REQ;
            end
            W_DADDR: begin
              shift_d = diff_data_q;
              src_d   = W_DDATA;
            end
            default: state_d = S_TRL;
          endcase
        end
      end
      S_MEM_FLAG: if (acc) begin
        wr_flag_d   = 1'b0;
        shift_d     = wr_addr_q;
        diff_data_d = wr_data_q;
        src_d       = W_DADDR;
        state_d     = wr_flag_q ? S_WORD_TX : S_TRL;
      end
      S_MEM_REQ: state_d = S_MEM_LAT;
      S_MEM_LAT: begin
        shift_d = bus.dmem_data_i;
        src_d   = W_MEM;
        state_d = S_WORD_TX;
      end
      S_TRL: state_d = acc ? S_DONE : S_TRL;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // a write landing in the same cycle the flag byte is consumed must not be lost
    if (bus.mem_we_i) begin
      wr_flag_d = 1'b1;
      wr_addr_d = bus.mem_waddr_i;
      wr_data_d = bus.mem_wdata_i;
    end
  end
  assign bus.tx_valid_o  = state_q inside {S_HDR, S_PC, S_WORD_TX, S_MEM_FLAG, S_TRL};
  assign bus.tx_data_o   = (state_q == S_HDR) ? HDR_BYTE :
                           (state_q == S_TRL) ? TRL_BYTE :
                           (state_q == S_MEM_FLAG) ? {7'd0, wr_flag_q} :
                           (state_q == S_PC || state_q == S_WORD_TX) ? shift_q[7:0] : 8'd0;
  assign bus.rf_addr_o   = rf_idx_q;
  assign bus.dmem_addr_o = dmem_addr_q;
  assign bus.done_o      = state_q == S_DONE;
  assign bus.busy_o      = state_q != S_IDLE;
endmodule

// File: tb/tb_dump_serializer.sv
// tb_dump_serializer: randomized frame checks of dump_serializer against a byte-list reference model.
module tb_dump_serializer;
  localparam int          MW = 4;
  localparam logic [31:0] MB = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  dump_serializer_if bus();
  dump_serializer #(.MEM_BASE(MB), .MEM_WORDS(MW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [31:0] rf [32];
  logic [31:0] mem [MW];
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];
  int          done_total = 0;
  logic        m_flag = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic        stall = 1'b0;
  logic [7:0]  stall_data = '0;
  logic        last_acc = 1'b0;
  logic [7:0]  last_byte = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, req);
    end
  endtask
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] i;
    i = (a - MB) >> 2;
    return (i < MW) ? mem[i[1:0]] : (32'hBAD0_0000 ^ a);
  endfunction
  function automatic void add32(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endfunction
  always @(posedge clk) begin
    bus.rf_data_i   <= rf[bus.rf_addr_o];
    bus.dmem_data_i <= mem_rd(bus.dmem_addr_o);
  end
  always @(negedge clk) begin
    if (stall) chk("hold", 32'({bus.tx_valid_o, bus.tx_data_o}), 32'({1'b1, stall_data}));
    if (bus.done_o) begin
      chk("done_after_trl", 32'({last_acc, last_byte}), 32'({1'b1, 8'hED}));
      done_total <= done_total + 1;
    end
    if (bus.tx_valid_o && bus.tx_ready_i) got.push_back(bus.tx_data_o);
    stall      <= bus.tx_valid_o && !bus.tx_ready_i && !rst;
    stall_data <= bus.tx_data_o;
    last_acc   <= bus.tx_valid_o && bus.tx_ready_i;
    last_byte  <= bus.tx_data_o;
  end
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.mem_we_i = 1'b1; bus.mem_waddr_i = a; bus.mem_wdata_i = d;
    @(posedge clk); #1;
    bus.mem_we_i = 1'b0;
    m_flag = 1'b1; m_addr = a; m_data = d;
  endtask
  task automatic run_frame(input logic mode, input logic [31:0] pc, input bit rnd,
                           input int retrig_at, input bit we_at_flag, input int abort_at, input string tag);
    int base, dbase, n, extra, cyc, len;
    bit fired_t, fired_w;
    exp_q.delete();
    exp_q.push_back(8'hDA);
    add32(pc);
    for (int r = 0; r < 32; r++) add32(rf[r]);
    if (mode) for (int i = 0; i < MW; i++) add32(mem[i]);
    else begin
      exp_q.push_back({7'd0, m_flag});
      if (m_flag) begin add32(m_addr); add32(m_data); end
      m_flag = 1'b0;
    end
    exp_q.push_back(8'hED);
    base = got.size(); dbase = done_total; extra = 0; fired_t = 0; fired_w = 0;
    @(posedge clk); #1;
    bus.trigger_i = 1'b1; bus.mem_mode_i = mode; bus.pc_i = pc;
    bus.tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (cyc = 0; cyc < 6000 && extra < 4; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) chk({tag, " busy"}, 32'(bus.busy_o), 32'd1);
      bus.trigger_i = 1'b0; bus.mem_we_i = 1'b0;
      bus.mem_mode_i = 1'($urandom); bus.pc_i = $urandom;
      bus.tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n = got.size() - base;
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1'b1; #1;
        chk({tag, " valid_async"}, 32'(bus.tx_valid_o), 32'd0);
        chk({tag, " busy_async"}, 32'(bus.busy_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk({tag, " no_done"}, 32'(done_total - dbase), 32'd0);
        m_flag = 1'b0; m_addr = '0; m_data = '0;
        return;
      end
      if (retrig_at >= 0 && n == retrig_at && !fired_t) begin
        bus.trigger_i = 1'b1; fired_t = 1;
      end
      if (we_at_flag && n == 133 && bus.tx_valid_o && !fired_w) begin
        bus.tx_ready_i = 1'b1; bus.mem_we_i = 1'b1;
        bus.mem_waddr_i = 32'h0000_0080; bus.mem_wdata_i = 32'h1234_5678; fired_w = 1;
      end
      if (done_total > dbase) extra++;
    end
    chk({tag, " done_count"}, 32'(done_total - dbase), 32'd1);
    chk({tag, " len"}, 32'(got.size() - base), 32'(exp_q.size()));
    len = (got.size() - base < exp_q.size()) ? got.size() - base : exp_q.size();
    for (int i = 0; i < len; i++) chk($sformatf("%s byte%0d", tag, i), 32'(got[base + i]), 32'(exp_q[i]));
    chk({tag, " idle"}, 32'(bus.busy_o), 32'd0);
    if (we_at_flag) begin m_flag = 1'b1; m_addr = 32'h0000_0080; m_data = 32'h1234_5678; end
  endtask
  initial begin
    bus.trigger_i = 1'b0; bus.mem_mode_i = 1'b0; bus.pc_i = '0; bus.mem_we_i = 1'b0;
    bus.mem_waddr_i = '0; bus.mem_wdata_i = '0; bus.tx_ready_i = 1'b1;
    for (int r = 0; r < 32; r++) rf[r] = 32'(r) * 32'h0101_0101;
    mem[0] = 32'h1122_3344; mem[1] = 32'h5566_7788; mem[2] = 32'h99AA_BBCC; mem[3] = 32'hDDEE_FF00;
    #1 rst = 1'b1;
    #1;
    chk("rst valid", 32'(bus.tx_valid_o), 32'd0);
    chk("rst busy", 32'(bus.busy_o), 32'd0);
    chk("rst done", 32'(bus.done_o), 32'd0);
    chk("rst data", 32'(bus.tx_data_o), 32'd0);
    chk("rst rf_addr", 32'(bus.rf_addr_o), 32'd0);
    chk("rst dmem_addr", bus.dmem_addr_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(1'b0, 32'h0000_0010, 0, -1, 0, -1, "step_nowr");
    do_write(32'h0000_0044, 32'hCAFE_F00D);
    run_frame(1'b0, 32'h0000_0010, 0, -1, 0, -1, "step_wr");
    run_frame(1'b0, 32'h0000_0014, 0, -1, 0, -1, "step_cleared");
    run_frame(1'b1, 32'h0000_0018, 0, -1, 0, -1, "cont");
    run_frame(1'b1, 32'h0000_0018, 1, -1, 0, -1, "cont_bp");
    do_write($urandom, $urandom);
    run_frame(1'b0, $urandom, 1, 20, 0, -1, "retrig");
    do_write(32'h0000_0040, 32'hA5A5_5A5A);
    run_frame(1'b0, $urandom, 1, -1, 1, -1, "we_at_flag");
    run_frame(1'b0, $urandom, 0, -1, 0, -1, "flag_kept");
    run_frame(1'b1, $urandom, 0, -1, 0, 50, "abort");
    run_frame(1'b0, 32'h0000_0020, 0, -1, 0, -1, "fresh");
    for (int k = 0; k < 4; k++) begin
      for (int r = 1; r < 32; r++) rf[r] = $urandom;
      for (int i = 0; i < MW; i++) mem[i] = $urandom;
      if ($urandom_range(0, 1) == 1) do_write($urandom, $urandom);
      run_frame(1'($urandom), $urandom, 1, -1, 0, -1, $sformatf("rand%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
